// File: rtl/caterpillar_pkg.sv
// Shared types and constants for the caterpillar rule engine.
package caterpillar_pkg;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned NUM_RULES = 20;
    localparam int unsigned COLOR_W   = 2;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned POS_W     = 3;
    localparam int unsigned SEG_W     = COLOR_W * DEPTH;

    typedef logic [COLOR_W-1:0] colour_t;

    localparam colour_t COLOUR_0 = 2'd0;
    localparam colour_t COLOUR_1 = 2'd1;
    localparam colour_t COLOUR_2 = 2'd2;
    localparam colour_t COLOUR_3 = 2'd3;

    localparam int unsigned RULE_HAS0       = 0;
    localparam int unsigned RULE_HAS1       = 1;
    localparam int unsigned RULE_HAS2       = 2;
    localparam int unsigned RULE_HAS3       = 3;
    localparam int unsigned RULE_ENDS_SAME  = 4;
    localparam int unsigned RULE_NO_ADJ_EQ  = 5;
    localparam int unsigned RULE_ALL_SAME   = 6;
    localparam int unsigned RULE_LEN_EVEN   = 7;
    localparam int unsigned RULE_LEN_ODD    = 8;
    localparam int unsigned RULE_CNT0_EVEN  = 9;
    localparam int unsigned RULE_PALINDROME = 10;
    localparam int unsigned RULE_NO_0_3     = 11;
    localparam int unsigned RULE_LEN_GE4    = 12;
    localparam int unsigned RULE_DISTINCT3  = 13;
    localparam int unsigned RULE_NONDEC     = 14;
    localparam int unsigned RULE_1_THEN_2   = 15;
    localparam int unsigned RULE_FIRST2     = 16;
    localparam int unsigned RULE_LAST3      = 17;
    localparam int unsigned RULE_CNT0_EQ1   = 18;
    localparam int unsigned RULE_SUM_MOD4   = 19;

    localparam logic [NUM_RULES-1:0] EMPTY_VALID = 20'hCCEE0;

    // Colour stored at segment idx of a flattened segment vector.
    function automatic colour_t seg_at(input logic [SEG_W-1:0] s, input logic [POS_W-1:0] idx);
        return s[{idx, 1'b0} +: COLOR_W];
    endfunction

endpackage

// File: rtl/caterpillar_rule_eval.sv
// Combinational evaluation of the 20 hidden rules over the live segments.
module caterpillar_rule_eval
    import caterpillar_pkg::*;
(
    input  logic [SEG_W-1:0]     seg,
    input  logic [LEN_W-1:0]     len,
    output logic [NUM_RULES-1:0] valid
);

    logic [3:0]       has;
    logic             adj_ok;
    logic             all_same;
    logic             pal;
    logic             no03;
    logic             nondec;
    logic             one2;
    logic [LEN_W-1:0] cnt0;
    logic [LEN_W-1:0] cnt1;
    colour_t          sum;
    colour_t          first;
    colour_t          last;
    colour_t          cur;
    colour_t          prev;
    logic [LEN_W-1:0] mirror;
    logic [2:0]       distinct;

    // Single pass over positions below len; later positions are masked out.
    always_comb begin
        has      = '0;
        adj_ok   = 1'b1;
        all_same = 1'b1;
        pal      = 1'b1;
        no03     = 1'b1;
        nondec   = 1'b1;
        one2     = 1'b1;
        cnt0     = '0;
        cnt1     = '0;
        sum      = '0;
        first    = seg_at(seg, 3'd0);
        last     = '0;
        cur      = '0;
        prev     = '0;
        mirror   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LEN_W'(i) < len) begin
                cur      = seg_at(seg, POS_W'(i));
                has[cur] = 1'b1;
                sum      = sum + cur;
                if (cur == COLOUR_0) cnt0 = cnt0 + 1'b1;
                if (cur == COLOUR_1) cnt1 = cnt1 + 1'b1;
                if (cur != first) all_same = 1'b0;
                if (i > 0) begin
                    prev = seg_at(seg, POS_W'(i - 1));
                    if (cur == prev) adj_ok = 1'b0;
                    if (prev == COLOUR_0 && cur == COLOUR_3) no03 = 1'b0;
                    if (cur < prev) nondec = 1'b0;
                end
                if (cur == COLOUR_1) begin
                    if (!((LEN_W'(i + 1) < len) && (seg_at(seg, POS_W'(i + 1)) == COLOUR_2)))
                        one2 = 1'b0;
                end
                mirror = len - 1'b1 - LEN_W'(i);
                if (seg_at(seg, POS_W'(mirror)) != cur) pal = 1'b0;
                if (LEN_W'(i + 1) == len) last = cur;
            end
        end
    end

    assign distinct = 3'(has[0]) + 3'(has[1]) + 3'(has[2]) + 3'(has[3]);

    always_comb begin
        valid                  = '0;
        valid[RULE_HAS0]       = has[0];
        valid[RULE_HAS1]       = has[1];
        valid[RULE_HAS2]       = has[2];
        valid[RULE_HAS3]       = has[3];
        valid[RULE_ENDS_SAME]  = (len != '0) && (first == last);
        valid[RULE_NO_ADJ_EQ]  = adj_ok;
        valid[RULE_ALL_SAME]   = all_same;
        valid[RULE_LEN_EVEN]   = ~len[0];
        valid[RULE_LEN_ODD]    = len[0];
        valid[RULE_CNT0_EVEN]  = ~cnt0[0];
        valid[RULE_PALINDROME] = pal;
        valid[RULE_NO_0_3]     = no03;
        valid[RULE_LEN_GE4]    = (len >= LEN_W'(4));
        valid[RULE_DISTINCT3]  = (distinct >= 3'd3);
        valid[RULE_NONDEC]     = nondec;
        valid[RULE_1_THEN_2]   = one2;
        valid[RULE_FIRST2]     = (len != '0) && (first == COLOUR_2);
        valid[RULE_LAST3]      = (len != '0) && (last == COLOUR_3);
        valid[RULE_CNT0_EQ1]   = (cnt0 == cnt1);
        valid[RULE_SUM_MOD4]   = (sum == COLOUR_0);
    end

endmodule

// File: rtl/caterpillar_rules.sv
// Caterpillar segment storage, append/erase command logic and random read port.
module caterpillar_rules
    import caterpillar_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic        erase,
    input  logic [1:0]  color,
    input  logic [2:0]  read_pos,
    output logic        empty,
    output logic        full,
    output logic [19:0] valid,
    output logic [1:0]  read_val,
    output logic        read_over
);

    logic [SEG_W-1:0] seg_q;
    logic [SEG_W-1:0] seg_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            len_q <= '0;
        end else begin
            seg_q <= seg_d;
            len_q <= len_d;
        end
    end

    // Erase wins over update; erased segments stay in storage, masked by len.
    always_comb begin
        seg_d = seg_q;
        len_d = len_q;
        if (erase && (len_q != '0)) begin
            len_d = len_q - 1'b1;
        end else if (update && (len_q != LEN_W'(DEPTH))) begin
            seg_d[{len_q[POS_W-1:0], 1'b0} +: COLOR_W] = color;
            len_d = len_q + 1'b1;
        end
    end

    assign empty     = (len_q == '0);
    assign full      = (len_q == LEN_W'(DEPTH));
    assign read_over = ({1'b0, read_pos} >= len_q);
    assign read_val  = read_over ? COLOUR_0 : seg_at(seg_q, read_pos);

    caterpillar_rule_eval u_rule_eval (
        .seg   (seg_q),
        .len   (len_q),
        .valid (valid)
    );

endmodule

// File: tb/tb_caterpillar_rules.sv
// Directed bench for caterpillar_rules with hand-computed rule vectors.
`timescale 1ns/1ps
module tb_caterpillar_rules;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic        erase;
    logic [1:0]  color;
    logic [2:0]  read_pos;
    logic        empty;
    logic        full;
    logic [19:0] valid;
    logic [1:0]  read_val;
    logic        read_over;

    int n_checks;
    int n_errors;

    caterpillar_rules dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .update    (update),
        .erase     (erase),
        .color     (color),
        .read_pos  (read_pos),
        .empty     (empty),
        .full      (full),
        .valid     (valid),
        .read_val  (read_val),
        .read_over (read_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command per clock; returns 1ns after the edge with inputs idle.
    task automatic cmd(input logic u, input logic e, input logic [1:0] c);
        update = u;
        erase  = e;
        color  = c;
        @(posedge clk);
        #1;
        update = 1'b0;
        erase  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        read_pos = 3'd0;
        #1;
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'hCCEE0);
        check({tag, "_rover"}, 32'(read_over), 32'd1);
        check({tag, "_rval"}, 32'(read_val), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        update   = 1'b0;
        erase    = 1'b0;
        color    = 2'd0;
        read_pos = 3'd0;
        rst_n    = 1'b0;
        #2;
        check_reset_state("in_reset");
        do_reset();
        cmd(1'b0, 1'b0, 2'd0);
        check_reset_state("idle");

        // Sequence 0,1,2
        cmd(1'b1, 1'b0, 2'd0);
        cmd(1'b1, 1'b0, 2'd1);
        cmd(1'b1, 1'b0, 2'd2);
        check("s012_valid", 32'(valid), 32'h4E927);
        check("s012_empty", 32'(empty), 32'd0);
        read_pos = 3'd1; #1;
        check("s012_rval1", 32'(read_val), 32'd1);
        check("s012_rover1", 32'(read_over), 32'd0);
        read_pos = 3'd2; #1;
        check("s012_rval2", 32'(read_val), 32'd2);
        read_pos = 3'd3; #1;
        check("s012_rover3", 32'(read_over), 32'd1);
        check("s012_rval3", 32'(read_val), 32'd0);

        // Single colour 3, then erase down to empty and past it
        do_reset();
        cmd(1'b1, 1'b0, 2'd3);
        check("s3_valid", 32'(valid), 32'h6CF78);
        read_pos = 3'd0; #1;
        check("s3_rval0", 32'(read_val), 32'd3);
        cmd(1'b0, 1'b1, 2'd0);
        check("erase_valid", 32'(valid), 32'hCCEE0);
        check("erase_empty", 32'(empty), 32'd1);
        cmd(1'b0, 1'b1, 2'd0);
        check_reset_state("erase_on_empty");

        // Fill with colour 2, ninth update ignored
        for (int i = 0; i < 8; i++) begin
            check("fill_notfull", 32'(full), 32'd0);
            cmd(1'b1, 1'b0, 2'd2);
        end
        check("fill_full8", 32'(full), 32'd1);
        check("fill_valid8", 32'(valid), 32'hDDED4);
        cmd(1'b1, 1'b0, 2'd1);
        check("fill_full9", 32'(full), 32'd1);
        check("fill_valid9", 32'(valid), 32'hDDED4);
        read_pos = 3'd7; #1;
        check("fill_rval7", 32'(read_val), 32'd2);
        check("fill_rover7", 32'(read_over), 32'd0);
        check("fill_bit5", 32'(valid[5]), 32'd0);
        check("fill_bit6", 32'(valid[6]), 32'd1);
        check("fill_bit19", 32'(valid[19]), 32'd1);

        // Erase then re-append over a masked stale segment
        cmd(1'b0, 1'b1, 2'd0);
        check("fill_erase_full", 32'(full), 32'd0);
        read_pos = 3'd7; #1;
        check("fill_erase_rover7", 32'(read_over), 32'd1);
        check("fill_erase_rval7", 32'(read_val), 32'd0);
        cmd(1'b1, 1'b0, 2'd3);
        check("fill_reapp_rval7", 32'(read_val), 32'd3);

        // Update together with erase at len 2: erase wins
        do_reset();
        cmd(1'b1, 1'b0, 2'd1);
        cmd(1'b1, 1'b0, 2'd0);
        cmd(1'b1, 1'b1, 2'd3);
        read_pos = 3'd0; #1;
        check("both_rval0", 32'(read_val), 32'd1);
        read_pos = 3'd1; #1;
        check("both_rover1", 32'(read_over), 32'd1);
        check("both_valid", 32'(valid), 32'h04F72);

        // Asynchronous reset between edges, commands ignored while low
        cmd(1'b1, 1'b0, 2'd2);
        cmd(1'b1, 1'b0, 2'd3);
        check("pre_arst_empty", 32'(empty), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        update = 1'b1;
        color  = 2'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        update = 1'b0;
        check_reset_state("arst_cmd");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("arst_release");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
